// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: column scan, debounce on a divided tick,
// and a four-digit shift history for the display driver.
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] HEX3,
  output logic [3:0] HEX2,
  output logic [3:0] HEX1,
  output logic [3:0] HEX0,
  output logic       Load,
  output logic [3:0] KeyCode
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  // Bit position of the single low bit in a one-cold pattern.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else if (!v[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic single_low(input logic [3:0] v);
    logic [3:0] z;
    z = ~v;
    return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h2;
      4'd2:    k = 4'h3;
      4'd3:    k = 4'hA;
      4'd4:    k = 4'h4;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h6;
      4'd7:    k = 4'hB;
      4'd8:    k = 4'h7;
      4'd9:    k = 4'h8;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hC;
      4'd12:   k = 4'hE;
      4'd13:   k = 4'h0;
      4'd14:   k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]       sync1, srow;
  logic [DIV_W-1:0] div;
  logic             tick;

  state_t           state, state_d;
  logic [3:0]       col_d;
  logic [3:0]       pat, pat_d;
  logic [1:0]       ridx, ridx_d, cidx, cidx_d;
  logic [CNT_W-1:0] stab, stab_d, stab_inc;
  logic [3:0]       hex3_d, hex2_d, hex1_d, hex0_d, keycode_d;
  logic             load_d;
  logic [3:0]       col_rot, code;

  // Row synchronizer; idle level is all-high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 4'hF;
      srow  <= 4'hF;
    end else begin
      sync1 <= row;
      srow  <= sync1;
    end
  end

  // Scan tick divider.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DIV_W'(1);
  end

  assign tick     = (div == DIV_W'(SCAN_DIV - 1));
  assign stab_inc = stab + CNT_W'(1);
  assign col_rot  = {col[2:0], col[3]};
  assign code     = key_code(ridx, cidx);

  // Next-state and next-output logic, evaluated only on scan ticks.
  always_comb begin
    state_d   = state;
    col_d     = col;
    pat_d     = pat;
    ridx_d    = ridx;
    cidx_d    = cidx;
    stab_d    = stab;
    hex3_d    = HEX3;
    hex2_d    = HEX2;
    hex1_d    = HEX1;
    hex0_d    = HEX0;
    keycode_d = KeyCode;
    load_d    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single_low(srow)) begin
            pat_d   = srow;
            ridx_d  = low_idx(srow);
            cidx_d  = low_idx(col);
            stab_d  = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_rot;
          end
        end
        DEBOUNCE: begin
          // A matching pattern is one-cold by construction, so multi-key never accepts.
          if (srow == pat) begin
            stab_d = stab_inc;
            if (stab_inc == CNT_W'(DEBOUNCE_TICKS)) begin
              state_d   = HELD;
              hex3_d    = HEX2;
              hex2_d    = HEX1;
              hex1_d    = HEX0;
              hex0_d    = code;
              keycode_d = code;
              load_d    = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_rot;
          end
        end
        HELD: begin
          if (srow == 4'hF) begin
            stab_d  = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (srow == 4'hF) begin
            stab_d = stab_inc;
            if (stab_inc == CNT_W'(DEBOUNCE_TICKS)) begin
              state_d = SCAN;
              col_d   = col_rot;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= SCAN;
      col     <= 4'b1110;
      pat     <= 4'hF;
      ridx    <= 2'd0;
      cidx    <= 2'd0;
      stab    <= '0;
      HEX3    <= 4'd0;
      HEX2    <= 4'd0;
      HEX1    <= 4'd0;
      HEX0    <= 4'd0;
      KeyCode <= 4'd0;
      Load    <= 1'b0;
    end else begin
      state   <= state_d;
      col     <= col_d;
      pat     <= pat_d;
      ridx    <= ridx_d;
      cidx    <= cidx_d;
      stab    <= stab_d;
      HEX3    <= hex3_d;
      HEX2    <= hex2_d;
      HEX1    <= hex1_d;
      HEX0    <= hex0_d;
      KeyCode <= keycode_d;
      Load    <= load_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry with a behavioural 4x4 key matrix.
module tb_keypad_entry;

  localparam int unsigned SD = 4;
  localparam int unsigned DT = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] row, col, HEX3, HEX2, HEX1, HEX0, KeyCode;
  logic       Load;

  logic [15:0] keys;
  logic        raw_mode, glitch;
  logic [3:0]  raw_row;
  logic [15:0] hist;
  logic [3:0]  kmap [16];
  logic [19:0] q [$];

  int checks   = 0;
  int errors   = 0;
  int load_cnt = 0;
  logic prev_load = 1'b0;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .Clock(Clock), .Reset(Reset), .row(row), .col(col),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
    .Load(Load), .KeyCode(KeyCode)
  );

  always #5 Clock = ~Clock;

  // Matrix: a row goes low when a pressed key in it sits on the driven column.
  always_comb begin
    row = 4'hF;
    if (glitch)        row = 4'hF;
    else if (raw_mode) row = raw_row;
    else
      for (int r = 0; r < 4; r++)
        row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every Load must match the oldest expected entry.
  always @(negedge Clock) begin
    if (Reset) begin
      if (Load) begin
        load_cnt <= load_cnt + 1;
        chk("load_consecutive", 32'({prev_load, Load}), 32'h1);
        chk("load_expected", 32'(q.size() > 0), 32'h1);
        if (q.size() > 0)
          chk("load_data", 32'({HEX3, HEX2, HEX1, HEX0, KeyCode}), 32'(q.pop_front()));
      end
    end
    prev_load <= Load;
  end

  task automatic push_key(input int r, input int c);
    logic [3:0] kc;
    kc   = kmap[r*4 + c];
    hist = {hist[11:0], kc};
    q.push_back({hist, kc});
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_col", 32'(col), 32'hE);
    chk("rst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0);
    chk("rst_keycode", 32'(KeyCode), 32'h0);
    chk("rst_load", 32'(Load), 32'h0);
    hist = 16'h0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic wait_load(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(posedge Clock);
      n++;
      @(negedge Clock);
      if (Load) break;
    end
    chk("load_seen", 32'(Load), 32'h1);
  endtask

  task automatic release_all();
    keys = 16'h0;
    repeat (12 * SD) @(negedge Clock);
  endtask

  task automatic press(input int r, input int c);
    int n;
    push_key(r, c);
    keys[r*4 + c] = 1'b1;
    wait_load(200, n);
    release_all();
  endtask

  task automatic check_rotation(input string tag);
    logic [3:0] c0;
    @(negedge Clock);
    c0 = col;
    repeat (SD) @(negedge Clock);
    chk(tag, 32'(col), 32'({c0[2:0], c0[3]}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, lc0;
    Reset    = 1'b0;
    keys     = 16'h0;
    raw_mode = 1'b0;
    raw_row  = 4'hF;
    glitch   = 1'b0;
    hist     = 16'h0;
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    // Key 5 held from reset: accepted on the 20th edge after deassertion.
    keys[1*4 + 1] = 1'b1;
    do_reset();
    push_key(1, 1);
    wait_load(200, n);
    chk("latency_key5", 32'(n), 32'd20);
    @(negedge Clock);
    chk("load_drop", 32'(Load), 32'h0);
    chk("hex_key5", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0005);
    release_all();

    // Sequence 1,2,3,4 then #.
    do_reset();
    lc0 = load_cnt;
    press(0, 0);
    press(0, 1);
    press(0, 2);
    press(1, 0);
    chk("hex_after4", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h1234);
    press(3, 2);
    chk("hex_after_hash", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h234F);
    chk("loads_seq", 32'(load_cnt - lc0), 32'd5);

    // Two-tick bounce on row 1 must abort.
    raw_mode = 1'b1;
    lc0 = load_cnt;
    @(negedge Clock);
    raw_row = 4'b1101;
    repeat (2 * SD) @(negedge Clock);
    raw_row = 4'hF;
    repeat (4 * SD) @(negedge Clock);
    check_rotation("rotate_bounce");
    repeat (6 * SD) @(negedge Clock);
    chk("loads_bounce", 32'(load_cnt - lc0), 32'd0);
    raw_mode = 1'b0;

    // Key 0 held 50 ticks with a one-tick glitch: single acceptance.
    lc0 = load_cnt;
    push_key(3, 1);
    keys[3*4 + 1] = 1'b1;
    wait_load(200, n);
    repeat (20 * SD) @(negedge Clock);
    glitch = 1'b1;
    repeat (SD) @(negedge Clock);
    glitch = 1'b0;
    repeat (25 * SD) @(negedge Clock);
    chk("loads_hold", 32'(load_cnt - lc0), 32'd1);
    release_all();
    chk("hex_hold", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h34F0);

    // Two rows on one column: never accepted, scanning continues.
    lc0 = load_cnt;
    keys[0*4 + 2] = 1'b1;
    keys[2*4 + 2] = 1'b1;
    repeat (20 * SD) @(negedge Clock);
    chk("loads_multi", 32'(load_cnt - lc0), 32'd0);
    check_rotation("rotate_multi");
    release_all();

    // Reset during debounce of 9, then full re-debounce.
    do_reset();
    press(2, 0);
    chk("hex_key7", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0007);
    keys[2*4 + 2] = 1'b1;
    n = 0;
    while (col != 4'b1011 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk("col_reach", 32'(col), 32'hB);
    repeat (2 * SD) @(negedge Clock);
    do_reset();
    push_key(2, 2);
    wait_load(200, n);
    chk("latency_key9", 32'(n), 32'd24);
    chk("hex_key9", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0009);
    release_all();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning Clock cycles per scan tick (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, meaning consecutive stable ticks for press or release (minimum 1).
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, externally pulled up, asynchronous to Clock.
REQ-006 SHALL have port col  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have ports HEX3, HEX2, HEX1, HEX0  output  4 each  entered digits, HEX0 newest; they feed the 4-digit display driver directly.
REQ-008 SHALL have port Load  output  1  one-cycle strobe marking new HEX3..HEX0 contents.
REQ-009 SHALL have port KeyCode  output  4  code of the last accepted key.

Function
REQ-010 SHALL pass row through a two-flop synchronizer; all decisions use the synchronized value (srow).
REQ-011 SHALL run a free counter generating a one-cycle tick every SCAN_DIV Clock cycles; it wraps to 0 after SCAN_DIV-1.
REQ-012 SHALL evaluate srow only in cycles where tick is high; FSM is frozen otherwise.
REQ-013 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN on tick: exactly one srow bit low -> latch row/column index, clear stable count, go DEBOUNCE, col unchanged; otherwise rotate col (1110->1101->1011->0111->1110).
REQ-015 DEBOUNCE on tick: srow equals latched pattern -> increment count; count reaching DEBOUNCE_TICKS -> accept key, go HELD; any mismatch -> go SCAN and rotate col.
REQ-016 Accept SHALL, on that same edge, shift HEX3<=HEX2, HEX2<=HEX1, HEX1<=HEX0, HEX0<=code, KeyCode<=code, Load<=1.
REQ-017 Load SHALL return to 0 on the following edge; never high two consecutive cycles.
REQ-018 Key map (row r, col c -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: * =E, 0, # =F, D.
REQ-019 HELD: col held; on tick srow==1111 -> clear count, go RELEASE; else stay (no repeat, no Load).
REQ-020 RELEASE on tick: srow==1111 -> increment count, count reaching DEBOUNCE_TICKS -> go SCAN and rotate col; any low bit -> go HELD.
REQ-021 Two or more srow bits low SHALL never start or complete an accept (SCAN rotates; DEBOUNCE aborts).
REQ-022 Digit history SHALL persist indefinitely; oldest digit (HEX3) is discarded on shift.

Reset
REQ-023 Reset low SHALL immediately force: state SCAN, col=1110, HEX3..HEX0=0, KeyCode=0, Load=0, tick counter=0, stable count=0, synchronizer flops=1111.
REQ-024 Reset asserted mid-DEBOUNCE or HELD SHALL abort with no Load; after release, a still-pressed key requires full debounce before acceptance.
REQ-025 Deassertion SHALL be taken synchronously; first tick occurs SCAN_DIV cycles after deassertion.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-026 Press key row1/col1 until accept -> HEX0=5, HEX3..HEX1=0, KeyCode=5, Load high exactly one cycle, on the 3rd tick after the capture tick.
REQ-027 Press/release 1,2,3,4 then #, each held and released cleanly -> after 4th key {HEX3..HEX0}=1,2,3,4; after # {HEX3..HEX0}=2,3,4,F; exactly 5 Load pulses.
REQ-028 Row1 low for 2 ticks then high (bounce) -> no Load, FSM back in SCAN, col rotates.
REQ-029 Hold key 0 for 50 ticks, with 1-tick high glitch mid-hold -> exactly one Load, HEX0=0 code shifted once.
REQ-030 Rows 0 and 2 low simultaneously on same column -> no Load for 20 ticks; col keeps rotating.
REQ-031 Assert Reset during DEBOUNCE of key 9 with HEX0=7 -> HEX all 0, col=1110, Load=0 immediately; key still held after release -> HEX0=9 after full debounce.
